// File: rtl/palette_pkg.sv
// Shared constants and types for the palette encoder.
// Holds the palette geometry, the distance width, the encoder FSM state type,
// the RGB channel slice positions and the per-channel absolute-difference helper.
package palette_pkg;

    localparam int unsigned NUM_ENTRIES = 23;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned COLOR_W     = 24;
    localparam int unsigned DIST_W      = 10;

    // Channel layout inside a packed colour: R[23:16] G[15:8] B[7:0]
    localparam int unsigned CH_W  = 8;
    localparam int unsigned R_LSB = 16;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned B_LSB = 0;

    // Starting "best" distance; larger than any reachable distance (max 765)
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    // Unsigned |a - b| of one colour channel
    function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                                 input logic [CH_W-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/palette_encoder_if.sv
// Request / palette-read / result bundle of the palette encoder.
//   rgb_In, req_valid, req_ready     : request handshake carrying the colour
//   pal_addr, pal_data               : palette ROM read port (1-cycle latency)
//   idx_Out, dist_Out, done_valid,
//   done_ready                       : result handshake
// master = requester + palette ROM side, slave = encoder.
interface palette_encoder_if;
    import palette_pkg::*;

    logic [COLOR_W-1:0] rgb_In;
    logic               req_valid;
    logic               req_ready;
    logic [IDX_W-1:0]   pal_addr;
    logic [COLOR_W-1:0] pal_data;
    logic [IDX_W-1:0]   idx_Out;
    logic [DIST_W-1:0]  dist_Out;
    logic               done_valid;
    logic               done_ready;

    modport master (
        output rgb_In, req_valid, pal_data, done_ready,
        input  req_ready, pal_addr, idx_Out, dist_Out, done_valid
    );

    modport slave (
        input  rgb_In, req_valid, pal_data, done_ready,
        output req_ready, pal_addr, idx_Out, dist_Out, done_valid
    );

endinterface

// File: rtl/color_dist.sv
// Combinational Manhattan distance between two packed RGB colours.
//   color_a, color_b : 24-bit colours R[23:16] G[15:8] B[7:0]
//   dist_c           : |dR| + |dG| + |dB|, 10 bits (max 765, cannot overflow)
module color_dist
    import palette_pkg::*;
(
    input  logic [COLOR_W-1:0] color_a,
    input  logic [COLOR_W-1:0] color_b,
    output logic [DIST_W-1:0]  dist_c
);

    logic [CH_W-1:0] d_r;
    logic [CH_W-1:0] d_g;
    logic [CH_W-1:0] d_b;

    // Per-channel differences widened before the sum
    always_comb begin
        d_r    = abs_diff(color_a[R_LSB +: CH_W], color_b[R_LSB +: CH_W]);
        d_g    = abs_diff(color_a[G_LSB +: CH_W], color_b[G_LSB +: CH_W]);
        d_b    = abs_diff(color_a[B_LSB +: CH_W], color_b[B_LSB +: CH_W]);
        dist_c = DIST_W'(d_r) + DIST_W'(d_g) + DIST_W'(d_b);
    end

endmodule

// File: rtl/palette_encoder.sv
// Nearest-palette-entry encoder: maps a 24-bit RGB colour to the index of the
// closest palette entry (Manhattan distance) by scanning the palette ROM.
//   Clk, Reset : clock, synchronous active-high reset
//   bus.slave  : request (rgb_In/req_valid/req_ready), palette read port
//                (pal_addr out, pal_data in, 1-cycle latency), result
//                (idx_Out/dist_Out/done_valid/done_ready)
// EXACT_EARLY_EXIT=1 ends the scan at the first distance-0 entry.
module palette_encoder
    import palette_pkg::*;
#(
    parameter bit EXACT_EARLY_EXIT = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    palette_encoder_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

    enc_state_t         state_q,      state_d;
    logic [IDX_W-1:0]   pal_addr_q,   pal_addr_d;
    logic [IDX_W-1:0]   scan_cnt_q,   scan_cnt_d;
    logic [COLOR_W-1:0] rgb_q,        rgb_d;
    logic [DIST_W-1:0]  best_dist_q,  best_dist_d;
    logic [IDX_W-1:0]   best_idx_q,   best_idx_d;
    logic [IDX_W-1:0]   idx_out_q,    idx_out_d;
    logic [DIST_W-1:0]  dist_out_q,   dist_out_d;
    logic               done_valid_q, done_valid_d;
    logic               req_ready_q,  req_ready_d;

    logic [DIST_W-1:0]  dist_c;
    logic [IDX_W-1:0]   cand_idx_c;

    // Distance between the latched request colour and the entry on pal_data
    color_dist u_color_dist (
        .color_a (rgb_q),
        .color_b (bus.pal_data),
        .dist_c  (dist_c)
    );

    // State and datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            pal_addr_q   <= '0;
            scan_cnt_q   <= '0;
            rgb_q        <= '0;
            best_dist_q  <= DIST_MAX;
            best_idx_q   <= '0;
            idx_out_q    <= '0;
            dist_out_q   <= '0;
            done_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            pal_addr_q   <= pal_addr_d;
            scan_cnt_q   <= scan_cnt_d;
            rgb_q        <= rgb_d;
            best_dist_q  <= best_dist_d;
            best_idx_q   <= best_idx_d;
            idx_out_q    <= idx_out_d;
            dist_out_q   <= dist_out_d;
            done_valid_q <= done_valid_d;
            req_ready_q  <= req_ready_d;
        end
    end

    // Next-state and datapath logic.
    // scan_cnt_q counts SCAN edges since acceptance; the first SCAN edge only
    // fills the ROM pipeline, afterwards pal_data holds entry scan_cnt_q-1.
    always_comb begin
        state_d      = state_q;
        pal_addr_d   = pal_addr_q;
        scan_cnt_d   = scan_cnt_q;
        rgb_d        = rgb_q;
        best_dist_d  = best_dist_q;
        best_idx_d   = best_idx_q;
        idx_out_d    = idx_out_q;
        dist_out_d   = dist_out_q;
        done_valid_d = done_valid_q;
        cand_idx_c   = scan_cnt_q - IDX_W'(1);

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    rgb_d       = bus.rgb_In;
                    pal_addr_d  = '0;
                    scan_cnt_d  = '0;
                    best_dist_d = DIST_MAX;
                    best_idx_d  = '0;
                    state_d     = SCAN;
                end
            end

            SCAN: begin
                if (pal_addr_q != LAST_IDX) begin
                    pal_addr_d = pal_addr_q + IDX_W'(1);
                end
                scan_cnt_d = scan_cnt_q + IDX_W'(1);

                if (scan_cnt_q != '0) begin
                    // Strict less-than keeps the lowest index on ties
                    if (dist_c < best_dist_q) begin
                        best_dist_d = dist_c;
                        best_idx_d  = cand_idx_c;
                    end
                    if ((cand_idx_c == LAST_IDX) ||
                        (EXACT_EARLY_EXIT && (dist_c == '0))) begin
                        idx_out_d    = best_idx_d;
                        dist_out_d   = best_dist_d;
                        done_valid_d = 1'b1;
                        state_d      = DONE;
                    end
                end
            end

            DONE: begin
                if (bus.done_ready) begin
                    done_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.pal_addr   = pal_addr_q;
    assign bus.idx_Out    = idx_out_q;
    assign bus.dist_Out   = dist_out_q;
    assign bus.done_valid = done_valid_q;

endmodule

// File: tb/tb_palette_encoder.sv
// Directed bench for palette_encoder: two instances (early exit on / off) share
// clock and reset; each reads its own behavioural copy of the test palette.
// Inputs change and outputs are sampled 1 time unit after the rising edge;
// latency n means done_valid is first seen after edge E(n), E0 = acceptance.
module tb_palette_encoder;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    palette_encoder_if bus0 ();
    palette_encoder_if bus1 ();

    palette_encoder #(.EXACT_EARLY_EXIT(1'b1)) dut0 (.Clk(clk), .Reset(reset), .bus(bus0));
    palette_encoder #(.EXACT_EARLY_EXIT(1'b0)) dut1 (.Clk(clk), .Reset(reset), .bus(bus1));

    // Test palette: 0=000000 3=0A0000 5=FF0000 7=000A00 22=FFFFFF, rest 808080
    function automatic logic [23:0] rom_entry(input logic [4:0] a);
        case (a)
            5'd0:    return 24'h000000;
            5'd3:    return 24'h0A0000;
            5'd5:    return 24'hFF0000;
            5'd7:    return 24'h000A00;
            5'd22:   return 24'hFFFFFF;
            default: return 24'h808080;
        endcase
    endfunction

    // Synchronous-read palette ROMs, one cycle of latency
    logic [23:0] rom0_q, rom1_q;
    always @(posedge clk) begin
        rom0_q <= rom_entry(bus0.pal_addr);
        rom1_q <= rom_entry(bus1.pal_addr);
    end
    assign bus0.pal_data = rom0_q;
    assign bus1.pal_data = rom1_q;

    // Per-unit drive and observe vectors (index 0 = early exit, 1 = full scan)
    logic [1:0]  req_valid_r;
    logic [1:0]  done_ready_r;
    logic [23:0] rgb_r [2];
    logic [1:0]  done_valid_w;
    logic [1:0]  req_ready_w;
    logic [4:0]  idx_w  [2];
    logic [9:0]  dist_w [2];
    logic [4:0]  addr_w [2];

    assign bus0.req_valid  = req_valid_r[0];
    assign bus0.done_ready = done_ready_r[0];
    assign bus0.rgb_In     = rgb_r[0];
    assign bus1.req_valid  = req_valid_r[1];
    assign bus1.done_ready = done_ready_r[1];
    assign bus1.rgb_In     = rgb_r[1];

    assign done_valid_w = {bus1.done_valid, bus0.done_valid};
    assign req_ready_w  = {bus1.req_ready,  bus0.req_ready};
    assign idx_w[0]  = bus0.idx_Out;
    assign idx_w[1]  = bus1.idx_Out;
    assign dist_w[0] = bus0.dist_Out;
    assign dist_w[1] = bus1.dist_Out;
    assign addr_w[0] = bus0.pal_addr;
    assign addr_w[1] = bus1.pal_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Issue one request on unit u and return the edge count to done_valid (-1 on timeout)
    task automatic run_req(input int u, input logic [23:0] rgb, output int lat);
        rgb_r[u]       = rgb;
        req_valid_r[u] = 1'b1;
        @(posedge clk); #1;
        req_valid_r[u] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done_valid_w[u]) begin
                lat = n;
                break;
            end
        end
    endtask

    // Pulse done_ready for one edge on unit u
    task automatic release_result(input int u);
        done_ready_r[u] = 1'b1;
        @(posedge clk); #1;
        done_ready_r[u] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (req_ready_w[0] !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready0 got %b want 1", req_ready_w[0]); end
        n_cmp++; if (req_ready_w[1] !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready1 got %b want 1", req_ready_w[1]); end
        n_cmp++; if (done_valid_w !== 2'b00) begin n_bad++; $display("FAIL reset_done_valid got %b want 00", done_valid_w); end
        n_cmp++; if (addr_w[0] !== 5'd0) begin n_bad++; $display("FAIL reset_pal_addr got %0d want 0", addr_w[0]); end
        n_cmp++; if (idx_w[0] !== 5'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", idx_w[0]); end
        n_cmp++; if (dist_w[0] !== 10'd0) begin n_bad++; $display("FAIL reset_dist got %0d want 0", dist_w[0]); end
    endtask

    task automatic test_exact_early_exit();
        int lat;
        n_cmp++; if (req_ready_w[0] !== 1'b1) begin n_bad++; $display("FAIL exact_req_ready got %b want 1", req_ready_w[0]); end
        run_req(0, 24'hFF0000, lat);
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL exact_latency got %0d want 7", lat); end
        n_cmp++; if (idx_w[0] !== 5'd5) begin n_bad++; $display("FAIL exact_idx got %0d want 5", idx_w[0]); end
        n_cmp++; if (dist_w[0] !== 10'd0) begin n_bad++; $display("FAIL exact_dist got %0d want 0", dist_w[0]); end
        n_cmp++; if (req_ready_w[0] !== 1'b0) begin n_bad++; $display("FAIL exact_busy got %b want 0", req_ready_w[0]); end
        release_result(0);
        n_cmp++; if (done_valid_w[0] !== 1'b0) begin n_bad++; $display("FAIL exact_release_done got %b want 0", done_valid_w[0]); end
        n_cmp++; if (req_ready_w[0] !== 1'b1) begin n_bad++; $display("FAIL exact_release_ready got %b want 1", req_ready_w[0]); end
    endtask

    // 101010: black is 48 away, but entry 3 (0A0000) is 6+16+16=38 and wins over entry 7 (also 38)
    task automatic test_full_scan();
        int lat;
        run_req(0, 24'h101010, lat);
        n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL scan_latency got %0d want 24", lat); end
        n_cmp++; if (idx_w[0] !== 5'd3) begin n_bad++; $display("FAIL scan_idx got %0d want 3", idx_w[0]); end
        n_cmp++; if (dist_w[0] !== 10'd38) begin n_bad++; $display("FAIL scan_dist got %0d want 38", dist_w[0]); end
        n_cmp++; if (addr_w[0] !== 5'd22) begin n_bad++; $display("FAIL scan_addr_hold got %0d want 22", addr_w[0]); end
        release_result(0);
    endtask

    task automatic test_tie();
        int lat;
        run_req(0, 24'h0A0A00, lat);
        n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL tie_latency got %0d want 24", lat); end
        n_cmp++; if (idx_w[0] !== 5'd3) begin n_bad++; $display("FAIL tie_idx got %0d want 3", idx_w[0]); end
        n_cmp++; if (dist_w[0] !== 10'd10) begin n_bad++; $display("FAIL tie_dist got %0d want 10", dist_w[0]); end
        release_result(0);
    endtask

    task automatic test_no_early_exit();
        int lat;
        run_req(1, 24'hFFFFFF, lat);
        n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL noee_white_latency got %0d want 24", lat); end
        n_cmp++; if (idx_w[1] !== 5'd22) begin n_bad++; $display("FAIL noee_white_idx got %0d want 22", idx_w[1]); end
        n_cmp++; if (dist_w[1] !== 10'd0) begin n_bad++; $display("FAIL noee_white_dist got %0d want 0", dist_w[1]); end
        release_result(1);
        run_req(1, 24'hFF0000, lat);
        n_cmp++; if (lat !== 24) begin n_bad++; $display("FAIL noee_red_latency got %0d want 24", lat); end
        n_cmp++; if (idx_w[1] !== 5'd5) begin n_bad++; $display("FAIL noee_red_idx got %0d want 5", idx_w[1]); end
        n_cmp++; if (dist_w[1] !== 10'd0) begin n_bad++; $display("FAIL noee_red_dist got %0d want 0", dist_w[1]); end
        release_result(1);
    endtask

    // 000A00 matches entry 7 exactly, compared at E9
    task automatic test_back_pressure();
        int lat;
        run_req(0, 24'h000A00, lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL bp_latency got %0d want 9", lat); end
        rgb_r[0] = 24'hFF0000;
        for (int c = 0; c < 10; c++) begin
            req_valid_r[0] = c[0];
            @(posedge clk); #1;
            n_cmp++;
            if (done_valid_w[0] !== 1'b1 || req_ready_w[0] !== 1'b0 ||
                idx_w[0] !== 5'd7 || dist_w[0] !== 10'd0) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d got done=%b ready=%b idx=%0d dist=%0d want 1 0 7 0",
                         c, done_valid_w[0], req_ready_w[0], idx_w[0], dist_w[0]);
            end
        end
        req_valid_r[0] = 1'b0;
        release_result(0);
        n_cmp++; if (done_valid_w[0] !== 1'b0) begin n_bad++; $display("FAIL bp_release_done got %b want 0", done_valid_w[0]); end
        n_cmp++; if (req_ready_w[0] !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", req_ready_w[0]); end
        run_req(0, 24'hFF0000, lat);
        n_cmp++; if (lat !== 7 || idx_w[0] !== 5'd5) begin n_bad++; $display("FAIL bp_next got lat=%0d idx=%0d want 7 5", lat, idx_w[0]); end
        release_result(0);
    endtask

    task automatic test_reset_mid_scan();
        int  lat;
        bit  seen_done;
        seen_done      = 1'b0;
        rgb_r[0]       = 24'h101010;
        req_valid_r[0] = 1'b1;
        @(posedge clk); #1;
        req_valid_r[0] = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk); #1;
            if (done_valid_w[0]) seen_done = 1'b1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++; if (req_ready_w[0] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got %b want 1", req_ready_w[0]); end
        for (int n = 0; n < 30; n++) begin
            if (done_valid_w[0]) seen_done = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_done got %b want 0", seen_done); end
        run_req(0, 24'hFF0000, lat);
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL rst_mid_latency got %0d want 7", lat); end
        n_cmp++; if (idx_w[0] !== 5'd5) begin n_bad++; $display("FAIL rst_mid_idx got %0d want 5", idx_w[0]); end
        release_result(0);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid_r  = 2'b00;
        done_ready_r = 2'b00;
        rgb_r[0]     = 24'h0;
        rgb_r[1]     = 24'h0;
        test_reset();
        test_exact_early_exit();
        test_full_scan();
        test_tie();
        test_no_early_exit();
        test_back_pressure();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
